alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised successor to the P4 datapath ALU.
- Widens the combinational operation set with AND/XOR/NOR, arithmetic shifts, LUI and signed/unsigned compare.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy handshake.
- Sits in the EX stage. The controller stalls on md_busy for any MFHI/MFLO or new mult/div.

Parameters:
- WIDTH, 32, datapath width in bits; must be even and ≥ 8.
- SHW, $clog2(WIDTH), width of the shift-amount field.
- MD_CYCLES, WIDTH, number of busy cycles for every MULT/DIV; must be between 1 and WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_a  in  WIDTH  operand A (rs).
- alu_b  in  WIDTH  operand B (rt or immediate).
- alu_op  in  4  combinational operation select.
- shamt  in  SHW  shift amount, taken from the instruction field or from alu_a[SHW-1:0].
- alu_c  out  WIDTH  combinational result.
- zero  out  1  alu_a == alu_b.
- less  out  1  signed alu_a < alu_b.
- lessu  out  1  unsigned alu_a < alu_b.
- ovf  out  1  signed overflow of ADD/SUB.
- md_start  in  1  launch md_op when md_busy=0.
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-op.
- md_busy  out  1  mult/div in progress.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: synchronous, active-high, on clk and reset. Outputs after reset:
  - hi=0, lo=0, md_busy=0.
  - The internal counter and partial registers are cleared.
  - Any in-flight operation is aborted and leaves no result.
- Combinational part: alu_c, zero, less, lessu and ovf are purely combinational, with no clock dependency. alu_op encoding:
  - 0 ADD; 1 SUB; 2 OR; 3 AND; 4 XOR; 5 NOR.
  - 6 SLL b<<shamt; 7 SRL b>>shamt; 8 SRA b>>>shamt, signed.
  - 9 SLT: {0…,less}; 10 SLTU: {0…,lessu}.
  - 11 LUI: b<<(WIDTH/2).
  - 12–15: alu_c=0.
- ADD/SUB arithmetic:
  - Both wrap modulo 2^WIDTH.
  - ovf=1 only for alu_op 0/1, when the operand signs make the true result unrepresentable. Otherwise ovf=0.
  - less is computed without overflow error; it equals the true signed comparison even when a−b overflows.
- Mult/div handshake:
  - Accepted only on an edge where md_start=1 and md_busy=0.
  - md_start while md_busy=1 is ignored; the caller must hold or re-issue it.
- MTHI/MTLO (op 4/5):
  - Write alu_a to hi or lo on the accepting edge.
  - md_busy stays 0; latency is 1 cycle.
- MULT/MULTU/DIV/DIVU (op 0–3):
  - Operands are latched on the accepting edge.
  - md_busy=1 from the next cycle for exactly MD_CYCLES cycles.
  - On the edge where md_busy returns to 0, {hi,lo} are updated in the same cycle.
  - hi/lo hold their old values for the whole busy period.
- MULT/MULTU result: {hi,lo} = full 2·WIDTH-bit product, signed or unsigned.
- DIV/DIVU result:
  - lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = dividend. Same MD_CYCLES latency; no exception.
- Signed DIV of the most-negative value by −1: lo = most-negative value, hi = 0.
- md_op 6/7 with md_start: no state change.
- Internal state: IDLE → (accept op 0–3) → RUN with counter = MD_CYCLES−1.
  - RUN decrements the counter each cycle.
  - When counter = 0, RUN writes hi/lo and returns to IDLE.
  - md_busy = (state == RUN).
- Back-to-back: a new md_start may be accepted on the edge immediately after md_busy falls, with no dead cycle.
- Reset asserted during RUN wins over completion; hi and lo go to 0.

Test Plan (WIDTH=32, MD_CYCLES=32 unless noted):
- Combinational ops:
  - ADD 0x7FFFFFFF+1 → alu_c=0x80000000, ovf=1.
  - SLT 0x80000000 vs 1 → alu_c=1, and lessu=0.
  - SRA 0x80000000 shamt 4 → 0xF8000000.
  - LUI b=0x1234 → 0x12340000.
- MULT −3×7, start at cycle 0:
  - md_busy=1 for cycles 1–32.
  - On cycle 33, hi=0xFFFFFFFF and lo=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- DIV corner cases:
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 → lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Handshake:
  - md_start MULT with 5×5 while busy → ignored, result of the original op only.
  - MTHI 0xAA during idle → hi=0xAA next cycle, md_busy stays 0.
- Reset:
  - Reset asserted at cycle 10 of a DIV → next cycle md_busy=0, hi=lo=0.
  - After reset, a fresh MULTU 3×4 completes with lo=12.
- Back-to-back and parameter coverage:
  - MULTU then DIVU issued on the cycle md_busy falls → both results correct, total 66 cycles.
  - Repeat with WIDTH=16, MD_CYCLES=4: MULT 0x8000×0x8000 → hi=0x4000, lo=0, busy exactly 4 cycles.

Source files
------------

// File: rtl/alu_mdu.sv
// EX-stage ALU with an iterative-latency multiply/divide unit and HI/LO registers.
// Combinational ops are independent of clk; mult/div results land in HI/LO after MD_CYCLES busy cycles.
module alu_mdu #(
  parameter int WIDTH     = 32,
  parameter int SHW       = $clog2(WIDTH),
  parameter int MD_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_op,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] alu_c,
  output logic             zero,
  output logic             less,
  output logic             lessu,
  output logic             ovf,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] op_a_reg, op_b_reg;
  logic [1:0]       op_sel_reg;
  logic             md_done;
  logic             accept, start_md;

  logic [WIDTH-1:0] sum, diff;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
  logic [2*WIDTH-1:0] md_result;

  // ---------------- combinational ALU ----------------
  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign zero  = (alu_a == alu_b);
  assign less  = ($signed(alu_a) < $signed(alu_b));
  assign lessu = (alu_a < alu_b);

  always_comb begin
    ovf = 1'b0;
    if (alu_op == 4'd0)
      ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
    else if (alu_op == 4'd1)
      ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
  end

  always_comb begin
    alu_c = '0;
    case (alu_op)
      4'd0:  alu_c = sum;
      4'd1:  alu_c = diff;
      4'd2:  alu_c = alu_a | alu_b;
      4'd3:  alu_c = alu_a & alu_b;
      4'd4:  alu_c = alu_a ^ alu_b;
      4'd5:  alu_c = ~(alu_a | alu_b);
      4'd6:  alu_c = alu_b << shamt;
      4'd7:  alu_c = alu_b >> shamt;
      4'd8:  alu_c = $signed(alu_b) >>> shamt;
      4'd9:  alu_c = {{(WIDTH-1){1'b0}}, less};
      4'd10: alu_c = {{(WIDTH-1){1'b0}}, lessu};
      4'd11: alu_c = alu_b << (WIDTH/2);
      default: alu_c = '0;
    endcase
  end

  // ---------------- mult/div result from latched operands ----------------
  // Op encoding: bit0 set means unsigned, bit1 set means divide.
  assign is_signed = ~op_sel_reg[0];
  assign ext_a = is_signed ? {{WIDTH{op_a_reg[WIDTH-1]}}, op_a_reg} : {{WIDTH{1'b0}}, op_a_reg};
  assign ext_b = is_signed ? {{WIDTH{op_b_reg[WIDTH-1]}}, op_b_reg} : {{WIDTH{1'b0}}, op_b_reg};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes so truncation toward zero and dividend-signed remainder fall out
  // naturally; MIN / -1 yields MIN with remainder 0 without a special case.
  assign a_neg = is_signed & op_a_reg[WIDTH-1];
  assign b_neg = is_signed & op_b_reg[WIDTH-1];
  assign mag_a = a_neg ? -op_a_reg : op_a_reg;
  assign mag_b = b_neg ? -op_b_reg : op_b_reg;
  assign div_b = (op_b_reg == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign q_mag = mag_a / div_b;
  assign r_mag = mag_a % div_b;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    md_result = prod;
    if (op_sel_reg[1]) begin
      if (op_b_reg == '0) md_result = {op_a_reg, {WIDTH{1'b1}}};
      else                md_result = {rem, quot};
    end
  end

  // ---------------- control FSM ----------------
  assign accept   = md_start & ~md_busy;
  assign start_md = accept & ~md_op[2];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_md) state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    md_busy = (state_reg == RUN);
    md_done = (state_reg == RUN) && (cnt_reg == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_sel_reg <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      if (start_md) begin
        cnt_reg    <= CNT_LOAD;
        op_a_reg   <= alu_a;
        op_b_reg   <= alu_b;
        op_sel_reg <= md_op[1:0];
      end else if (md_busy && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (md_done) begin
        hi <= md_result[2*WIDTH-1:WIDTH];
        lo <= md_result[WIDTH-1:0];
      end else if (accept && md_op == 3'd4) begin
        hi <= alu_a;
      end else if (accept && md_op == 3'd5) begin
        lo <= alu_a;
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: a 32-bit/32-cycle instance and a 16-bit/4-cycle instance.
module tb_alu_mdu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a32 = '0, b32 = '0, c32, hi32, lo32;
  logic [3:0]  op32 = '0;
  logic [4:0]  sh32 = '0;
  logic        zero32, less32, lessu32, ovf32, busy32;
  logic        st32 = 1'b0;
  logic [2:0]  mop32 = '0;

  logic [15:0] a16 = '0, b16 = '0, c16, hi16, lo16;
  logic [3:0]  op16 = '0;
  logic [3:0]  sh16 = '0;
  logic        zero16, less16, lessu16, ovf16, busy16;
  logic        st16 = 1'b0;
  logic [2:0]  mop16 = '0;

  int total = 0;
  int bad = 0;
  int cyc;

  alu_mdu #(.WIDTH(32), .MD_CYCLES(32)) u32 (
    .clk(clk), .reset(reset), .alu_a(a32), .alu_b(b32), .alu_op(op32), .shamt(sh32),
    .alu_c(c32), .zero(zero32), .less(less32), .lessu(lessu32), .ovf(ovf32),
    .md_start(st32), .md_op(mop32), .md_busy(busy32), .hi(hi32), .lo(lo32));

  alu_mdu #(.WIDTH(16), .MD_CYCLES(4)) u16 (
    .clk(clk), .reset(reset), .alu_a(a16), .alu_b(b16), .alu_op(op16), .shamt(sh16),
    .alu_c(c16), .zero(zero16), .less(less16), .lessu(lessu16), .ovf(ovf16),
    .md_start(st16), .md_op(mop16), .md_busy(busy16), .hi(hi16), .lo(lo16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh);
    op32 = op; a32 = a; b32 = b; sh32 = sh;
    #1;
  endtask

  // Launch on the next edge, then wait (bounded) for busy to drop; n = edges consumed.
  task automatic md32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int n);
    mop32 = op; a32 = a; b32 = b; st32 = 1'b1;
    tick();
    st32 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D;
    n = 1;
    while (busy32 && n < 200) begin
      tick();
      n++;
    end
    check("md32_settled", {63'd0, busy32}, 64'd0);
  endtask

  initial begin
    // ---- reset ----
    tick(); tick();
    check("rst_hi", hi32, 0);
    check("rst_lo", lo32, 0);
    check("rst_busy", busy32, 0);
    check("rst_busy16", busy16, 0);
    reset = 1'b0;

    // ---- combinational ops ----
    alu(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    check("add_c", c32, 64'h8000_0000);
    check("add_ovf", ovf32, 1);
    alu(4'd1, 32'h8000_0000, 32'h1, 5'd0);
    check("sub_c", c32, 64'h7FFF_FFFF);
    check("sub_ovf", ovf32, 1);
    check("sub_less", less32, 1);
    alu(4'd9, 32'h8000_0000, 32'h1, 5'd0);
    check("slt_c", c32, 1);
    check("slt_lessu", lessu32, 0);
    check("slt_ovf", ovf32, 0);
    alu(4'd10, 32'h8000_0000, 32'h1, 5'd0);
    check("sltu_c", c32, 0);
    alu(4'd8, 32'h0, 32'h8000_0000, 5'd4);
    check("sra_c", c32, 64'hF800_0000);
    alu(4'd7, 32'h0, 32'h8000_0000, 5'd4);
    check("srl_c", c32, 64'h0800_0000);
    alu(4'd6, 32'h0, 32'h0000_0003, 5'd31);
    check("sll_c", c32, 64'h8000_0000);
    alu(4'd11, 32'h0, 32'h0000_1234, 5'd0);
    check("lui_c", c32, 64'h1234_0000);
    alu(4'd5, 32'hF0F0_0000, 32'h0000_000F, 5'd0);
    check("nor_c", c32, 64'h0F0F_FFF0);
    alu(4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    check("xor_c", c32, 64'hF0F0_F0F0);
    check("xor_zero", zero32, 0);
    alu(4'd13, 32'h1234_5678, 32'h1234_5678, 5'd0);
    check("op13_c", c32, 0);
    check("op13_zero", zero32, 1);

    // ---- MTHI / MTLO, then MULT -3*7 cycle by cycle ----
    a32 = 32'h55; mop32 = 3'd4; st32 = 1'b1; tick();
    a32 = 32'h66; mop32 = 3'd5; tick();
    st32 = 1'b0;
    check("mthi_hi", hi32, 64'h55);
    check("mtlo_lo", lo32, 64'h66);
    check("mt_busy", busy32, 0);

    a32 = -32'sd3; b32 = 32'd7; mop32 = 3'd0; st32 = 1'b1;
    tick();
    st32 = 1'b0; a32 = '0; b32 = '0;
    for (int i = 1; i <= 32; i++) begin
      check($sformatf("mult_busy_c%0d", i), busy32, 1);
      if (i == 1 || i == 32) check($sformatf("mult_hold_c%0d", i), {hi32, lo32}, 64'h55_0000_0066);
      tick();
    end
    check("mult_busy_c33", busy32, 0);
    check("mult_hi", hi32, 64'hFFFF_FFFF);
    check("mult_lo", lo32, 64'hFFFF_FFEB);

    // ---- MULTU with an ignored start while busy ----
    mop32 = 3'd1; a32 = 32'hFFFF_FFFF; b32 = 32'd2; st32 = 1'b1;
    tick();
    mop32 = 3'd0; a32 = 32'd5; b32 = 32'd5;
    cyc = 1;
    while (busy32 && cyc < 200) begin
      if (cyc == 31) st32 = 1'b0;
      tick();
      cyc++;
    end
    st32 = 1'b0;
    check("multu_cycles", cyc, 33);
    check("multu_hi", hi32, 1);
    check("multu_lo", lo32, 64'hFFFF_FFFE);
    tick();
    check("ignored_no_restart", busy32, 0);

    // ---- divide corners ----
    md32(3'd2, -32'sd7, 32'd2, cyc);
    check("div_lo", lo32, 64'hFFFF_FFFD);
    check("div_hi", hi32, 64'hFFFF_FFFF);
    md32(3'd3, 32'd7, 32'd0, cyc);
    check("divu0_lo", lo32, 64'hFFFF_FFFF);
    check("divu0_hi", hi32, 7);
    check("divu0_cycles", cyc, 33);
    md32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("divmin_lo", lo32, 64'h8000_0000);
    check("divmin_hi", hi32, 0);
    md32(3'd2, 32'd100, -32'sd7, cyc);
    check("divneg_lo", lo32, 64'hFFFF_FFF2);
    check("divneg_hi", hi32, 2);
    md32(3'd6, 32'd9, 32'd9, cyc);
    check("nop_cycles", cyc, 1);
    check("nop_hilo", {hi32, lo32}, 64'h2_FFFF_FFF2);

    // ---- MTHI during idle ----
    a32 = 32'hAA; mop32 = 3'd4; st32 = 1'b1; tick(); st32 = 1'b0;
    check("mthi_aa", hi32, 64'hAA);
    check("mthi_aa_busy", busy32, 0);

    // ---- reset in the middle of a DIV ----
    a32 = 32'd100; b32 = 32'd3; mop32 = 3'd2; st32 = 1'b1;
    tick();
    st32 = 1'b0;
    repeat (9) tick();
    check("div_mid_busy", busy32, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_run_busy", busy32, 0);
    check("rst_run_hilo", {hi32, lo32}, 0);
    repeat (30) tick();
    check("rst_run_no_result", {31'd0, busy32, hi32, lo32}, 0);
    md32(3'd1, 32'd3, 32'd4, cyc);
    check("post_rst_lo", lo32, 12);
    check("post_rst_hi", hi32, 0);

    // ---- back-to-back MULTU then DIVU ----
    mop32 = 3'd1; a32 = 32'd6; b32 = 32'd7; st32 = 1'b1;
    tick(); cyc = 1; st32 = 1'b0;
    while (busy32 && cyc < 200) begin tick(); cyc++; end
    check("b2b_first_lo", lo32, 42);
    mop32 = 3'd3; a32 = 32'd100; b32 = 32'd7; st32 = 1'b1;
    tick(); cyc++; st32 = 1'b0;
    check("b2b_second_busy", busy32, 1);
    while (busy32 && cyc < 200) begin tick(); cyc++; end
    check("b2b_total_cycles", cyc, 66);
    check("b2b_lo", lo32, 14);
    check("b2b_hi", hi32, 2);

    // ---- WIDTH=16, MD_CYCLES=4 ----
    op16 = 4'd0; a16 = 16'h7FFF; b16 = 16'h0001; #1;
    check("w16_add_ovf", {ovf16, c16}, 64'h1_8000);
    op16 = 4'd11; b16 = 16'h00AB; #1;
    check("w16_lui", c16, 64'hAB00);
    a16 = 16'h8000; b16 = 16'h8000; mop16 = 3'd0; st16 = 1'b1;
    tick();
    st16 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("w16_busy_c%0d", i), busy16, 1);
      tick();
    end
    check("w16_busy_end", busy16, 0);
    check("w16_hi", hi16, 64'h4000);
    check("w16_lo", lo16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
